// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM pipeline stage.
package mem_pkg;

  typedef enum logic {IDLE, REQ} state_t;

  localparam logic [3:0] BE_BYTE0  = 4'b0001;
  localparam logic [3:0] BE_WORD   = 4'hF;
  localparam int         TIMEOUT_W = 8;

  // MEM/WB bundle; an all-zero value is a bubble.
  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic [31:0] read_data;
    logic [31:0] result;
    logic [4:0]  rd;
  } wb_t;

  localparam wb_t WB_BUBBLE = '0;

endpackage

// File: rtl/mem_byte_lane.sv
// Little-endian lane steering: store data/byte enables out, aligned load data in.
module mem_byte_lane
  import mem_pkg::*;
(
  input  logic        word,
  input  logic [1:0]  lane,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] load_data
);

  logic [31:0] rdata_shifted;

  assign rdata_shifted = rdata >> {lane, 3'b000};

  // NOTE: every output is assigned on every path, so no latch is inferred.
  always_comb begin
    if (word) begin
      wdata     = store_data;
      be        = BE_WORD;
      load_data = rdata;
    end else begin
      wdata     = {4{store_data[7:0]}};
      be        = BE_BYTE0 << lane;
      load_data = {24'd0, rdata_shifted[7:0]};
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: req/ack data-memory access with timeout, lane alignment and MEM/WB register.
// Optional MEM_MISALIGN_TRAP_EN drops misaligned word accesses with a bus_err pulse.
module mem_stage
  import mem_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic        word,
  input  logic        regWrite,
  input  logic        memToReg,
  input  logic [31:0] result,
  input  logic [31:0] readData2,
  input  logic [4:0]  rd,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        wb_regWrite,
  output logic        wb_memToReg,
  output logic [31:0] wb_readData,
  output logic [31:0] wb_result,
  output logic [4:0]  wb_rd,
  output logic        bus_err
);

  state_t               state;
  logic [TIMEOUT_W-1:0] cnt;
  wb_t                  wb_q;
  wb_t                  pend_q;
  logic                 word_q;

  logic        access, misalign, timeout_hit;
  logic        lane_word;
  logic [1:0]  lane_sel;
  logic [31:0] lane_wdata, lane_ldata;
  logic [3:0]  lane_be;

  assign access = memRead | memWrite;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = word & (result[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // The lane steering sees the live instruction in IDLE and the latched one in REQ.
  assign lane_word = (state == IDLE) ? word : word_q;
  assign lane_sel  = (state == IDLE) ? result[1:0] : pend_q.result[1:0];

  mem_byte_lane u_lane (
    .word       (lane_word),
    .lane       (lane_sel),
    .store_data (readData2),
    .rdata      (dmem_rdata),
    .wdata      (lane_wdata),
    .be         (lane_be),
    .load_data  (lane_ldata)
  );

  assign timeout_hit = (state == REQ) && !dmem_ack &&
                       (cnt == TIMEOUT_W'(ACK_TIMEOUT - 1));

  assign stall = ((state == IDLE) && access && !misalign) ||
                 ((state == REQ) && !dmem_ack && !timeout_hit);

  assign wb_regWrite = wb_q.reg_write;
  assign wb_memToReg = wb_q.mem_to_reg;
  assign wb_readData = wb_q.read_data;
  assign wb_result   = wb_q.result;
  assign wb_rd       = wb_q.rd;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      wb_q       <= WB_BUBBLE;
      pend_q     <= WB_BUBBLE;
      word_q     <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_be    <= '0;
      bus_err    <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (access && misalign) begin
            wb_q    <= WB_BUBBLE;
            bus_err <= 1'b1;
          end else if (access) begin
            pend_q     <= '{reg_write: regWrite, mem_to_reg: memToReg,
                            read_data: 32'd0, result: result, rd: rd};
            word_q     <= word;
            dmem_req   <= 1'b1;
            dmem_we    <= memWrite;
            dmem_addr  <= {result[31:2], 2'b00};
            dmem_wdata <= lane_wdata;
            dmem_be    <= lane_be;
            cnt        <= '0;
            wb_q       <= WB_BUBBLE;
            state      <= REQ;
          end else begin
            wb_q <= '{reg_write: regWrite, mem_to_reg: memToReg,
                      read_data: 32'd0, result: result, rd: rd};
          end
        end
        REQ: begin
          if (dmem_ack || timeout_hit) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_be    <= '0;
            cnt        <= '0;
            state      <= IDLE;
          end else begin
            cnt <= cnt + TIMEOUT_W'(1);
          end

          if (dmem_ack) begin
            wb_q           <= pend_q;
            wb_q.read_data <= dmem_we ? 32'd0 : lane_ldata;
          end else begin
            wb_q    <= WB_BUBBLE;
            bus_err <= timeout_hit;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus randomized transactions vs a transaction-level model.
module tb_mem_stage;

  localparam int T = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        memRead, memWrite, word, regWrite, memToReg;
  logic [31:0] result, readData2;
  logic [4:0]  rd;
  logic        stall;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic        wb_regWrite, wb_memToReg;
  logic [31:0] wb_readData, wb_result;
  logic [4:0]  wb_rd;
  logic        bus_err;

  int checks   = 0;
  int failures = 0;

  mem_stage #(.ACK_TIMEOUT(T)) dut (
    .clock(clock), .reset(reset),
    .memRead(memRead), .memWrite(memWrite), .word(word),
    .regWrite(regWrite), .memToReg(memToReg),
    .result(result), .readData2(readData2), .rd(rd),
    .stall(stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .wb_regWrite(wb_regWrite), .wb_memToReg(wb_memToReg),
    .wb_readData(wb_readData), .wb_result(wb_result), .wb_rd(wb_rd),
    .bus_err(bus_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic set_nop();
    memRead = 0; memWrite = 0; word = 0; regWrite = 0; memToReg = 0;
    result = 0; readData2 = 0; rd = 0;
  endtask

  function automatic bit trap_expected(input logic w, input logic [31:0] addr);
    bit t;
    t = w && (addr[1:0] != 2'b00);
`ifndef MEM_MISALIGN_TRAP_EN
    t = 1'b0;
`endif
    return t;
  endfunction

  // Called at a negedge; returns at a negedge.
  task automatic run_alu(input logic rw, input logic mtr, input logic [31:0] res, input logic [4:0] r);
    memRead = 0; memWrite = 0; word = $urandom_range(0, 1);
    regWrite = rw; memToReg = mtr; result = res; readData2 = $urandom; rd = r;
    #1 check("alu_stall", stall, 0);
    @(posedge clock);
    @(negedge clock);
    check("alu_wb_regWrite", wb_regWrite, rw);
    check("alu_wb_memToReg", wb_memToReg, mtr);
    check("alu_wb_result", wb_result, res);
    check("alu_wb_rd", wb_rd, r);
    check("alu_dmem_req", dmem_req, 0);
  endtask

  // waits < 0 means the memory never acknowledges.
  task automatic run_mem(input logic rd_en, input logic wr_en, input logic wd,
                         input logic rw, input logic mtr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [4:0] r,
                         input int waits, input logic [31:0] rdata);
    int          lane;
    int          stalls;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata, exp_load;
    lane      = int'(addr[1:0]);
    exp_be    = wd ? 4'hF : 4'(1 << lane);
    exp_wdata = wd ? data : {4{data[7:0]}};
    exp_load  = wr_en ? 32'd0 : (wd ? rdata : ((rdata >> (8 * lane)) & 32'hFF));

    memRead = rd_en; memWrite = wr_en; word = wd; regWrite = rw; memToReg = mtr;
    result = addr; readData2 = data; rd = r; dmem_ack = 0;

    if (trap_expected(wd, addr)) begin
      #1 check("trap_stall", stall, 0);
      @(posedge clock);
      @(negedge clock);
      check("trap_dmem_req", dmem_req, 0);
      check("trap_bus_err", bus_err, 1);
      check("trap_wb_regWrite", wb_regWrite, 0);
      set_nop();
      return;
    end

    #1 check("accept_stall", stall, 1);
    stalls = 1;
    @(posedge clock);
    for (int i = 0; i < T; i++) begin
      @(negedge clock);
      if (i == 0) begin
        check("bubble_regWrite", wb_regWrite, 0);
        check("bubble_memToReg", wb_memToReg, 0);
        check("dmem_addr", dmem_addr, {addr[31:2], 2'b00});
        check("dmem_we", dmem_we, wr_en);
        check("dmem_be", dmem_be, exp_be);
        if (wr_en) check("dmem_wdata", dmem_wdata, exp_wdata);
      end
      check("dmem_req_held", dmem_req, 1);
      if (i == waits) begin
        dmem_ack   = 1;
        dmem_rdata = rdata;
      end
      #1 if (stall) stalls++;
      @(posedge clock);
      if (i == waits) break;
    end
    @(negedge clock);
    dmem_ack   = 0;
    dmem_rdata = $urandom;
    check("stall_cycles", stalls, (waits < 0) ? T : 1 + waits);
    check("dmem_req_drop", dmem_req, 0);
    if (waits >= 0) begin
      check("mem_wb_regWrite", wb_regWrite, rw);
      check("mem_wb_memToReg", wb_memToReg, mtr);
      check("mem_wb_readData", wb_readData, exp_load);
      check("mem_wb_result", wb_result, addr);
      check("mem_wb_rd", wb_rd, r);
      check("mem_bus_err", bus_err, 0);
    end else begin
      check("timeout_bus_err", bus_err, 1);
      check("timeout_wb_regWrite", wb_regWrite, 0);
      set_nop();
      @(posedge clock);
      @(negedge clock);
      check("timeout_bus_err_clear", bus_err, 0);
      check("timeout_stall", stall, 0);
    end
  endtask

  initial begin
    set_nop();
    dmem_ack = 0; dmem_rdata = 0; reset = 1;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    check("rst_dmem_req", dmem_req, 0);
    check("rst_wb_regWrite", wb_regWrite, 0);
    check("rst_wb_readData", wb_readData, 0);
    check("rst_bus_err", bus_err, 0);
    check("rst_stall", stall, 0);
    reset = 0;

    run_alu(1, 0, 32'h1234, 5'd5);
    run_mem(1, 0, 1, 1, 1, 32'h100, 32'h0, 5'd7, 3, 32'hDEADBEEF);
    run_mem(0, 1, 0, 0, 0, 32'h203, 32'h000000AB, 5'd0, 0, 32'h0);
    run_mem(1, 0, 0, 1, 1, 32'h301, 32'h0, 5'd9, 1, 32'h11FF2233);
    run_mem(1, 0, 1, 1, 1, 32'h400, 32'h0, 5'd3, -1, 32'h0);
    run_mem(1, 1, 1, 1, 0, 32'h504, 32'h89ABCDEF, 5'd11, 2, 32'h55555555);
    run_mem(1, 0, 1, 1, 1, 32'h102, 32'h0, 5'd4, 0, 32'hCAFEF00D);

    // A stray ack outside an access must not disturb pass-through.
    dmem_ack = 1;
    run_alu(1, 1, 32'hA5A5_0001, 5'd17);
    dmem_ack = 0;

    for (int n = 0; n < 40; n++) begin
      int kind;
      kind = $urandom_range(0, 3);
      if (kind == 0) begin
        run_alu(1'($urandom), 1'($urandom), $urandom, 5'($urandom));
      end else begin
        logic rd_en, wr_en;
        int   w;
        wr_en = 1'($urandom);
        rd_en = wr_en ? 1'($urandom) : 1'b1;
        w     = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, T - 1));
        run_mem(rd_en, wr_en, 1'($urandom), 1'($urandom), 1'($urandom),
                $urandom, $urandom, 5'($urandom), w, $urandom);
      end
    end

    // Reset while waiting for an ack abandons the access.
    memRead = 1; memWrite = 0; word = 1; regWrite = 1; memToReg = 1;
    result = 32'h600; rd = 5'd2; dmem_ack = 0;
    @(posedge clock);
    @(negedge clock);
    check("pre_rst_req", dmem_req, 1);
    @(posedge clock);
    @(negedge clock);
    reset = 1;
    set_nop();
    @(posedge clock);
    @(negedge clock);
    reset = 0;
    check("rst_req_dmem_req", dmem_req, 0);
    check("rst_req_stall", stall, 0);
    check("rst_req_wb_regWrite", wb_regWrite, 0);
    check("rst_req_wb_memToReg", wb_memToReg, 0);
    check("rst_req_wb_readData", wb_readData, 0);
    check("rst_req_wb_result", wb_result, 0);
    check("rst_req_wb_rd", wb_rd, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
